word_tokenizer: RTL
===================

Name: word_tokenizer

Overview:
- Upstream stage of the begin/end nesting checker: consumes a raw 8-bit ASCII character stream, one character per accepted cycle.
- Splits the stream into space-delimited words and classifies each word case-insensitively as BEGIN, END or OTHER.
- Emits one token per word, plus an end-of-stream marker, over a valid/ready interface. Tokens pass through a small output FIFO so that back-pressure from the checker stalls the character source.

Parameters:
- MAX_LEN, 15: saturation value of the per-word length counter; tok_len width is 4 bits, so MAX_LEN must be 15 or less.
- FIFO_DEPTH, 4: token FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  in_char / in_last are valid.
- in_ready  output  1  block accepts a character this cycle.
- in_char  input  8  ASCII character.
- in_last  input  1  this character is the final one of the stream.
- tok_valid  output  1  token at FIFO head is valid.
- tok_ready  input  1  consumer takes the head token this cycle.
- tok_kind  output  2  0 = OTHER, 1 = BEGIN, 2 = END, 3 = EOS.
- tok_len  output  4  word length saturated at MAX_LEN; 0 for EOS.

Behaviour:
- Reset (asynchronous, while reset = 0):
  - FIFO is emptied.
  - FSM goes to GAP; length counter and match flags are cleared.
  - Outputs: tok_valid = 0, in_ready = 0, tok_kind = 0, tok_len = 0.
  - in_ready rises on the first clk edge after reset deasserts.
  - Reset in mid-word or mid-stream discards all partial and queued tokens; nothing is emitted for them.
- Accept: a character is accepted when in_valid and in_ready are both 1 at a rising clk edge.
  - in_ready = 1 only when the FIFO has at least 2 free entries, because one character can push a word token plus EOS.
  - in_ready is a registered or purely FIFO-count-derived signal. It never depends combinationally on in_valid.
- Case folding: only 'A'..'Z' are mapped to 'a'..'z' (bit 5 set). All other bytes pass through unchanged.
- Delimiter: only 0x20 (space). Every other byte, including control characters and digits, is part of a word.
- FSM has two states, GAP and WORD.
  - GAP, delimiter accepted: stays in GAP, no token.
  - GAP, non-delimiter accepted: goes to WORD; length = 1; match flags are seeded from character position 0.
  - WORD, non-delimiter accepted: length increments, saturating at MAX_LEN. Match flags are updated; a flag is cleared on a mismatch or once position exceeds the keyword length.
  - WORD, delimiter accepted: pushes the word token and goes to GAP.
- Classification:
  - BEGIN only if the unsaturated word is exactly "begin" (length 5, all positions matched).
  - END only if the word is exactly "end" (length 3).
  - Anything else is OTHER; e.g. "beginx" and "en" are OTHER.
  - Words longer than MAX_LEN report tok_len = MAX_LEN and are always OTHER.
- in_last = 1 on an accepted character:
  - Non-delimiter: the character is included in the current word, the word token is pushed, then EOS is pushed in the same cycle (2 pushes, word first).
  - Delimiter: any pending word token is pushed, then EOS.
  - Empty stream or trailing spaces: only EOS is pushed.
  - FSM returns to GAP; the next accepted character starts a new stream.
- Latency: a token pushed on edge N is visible with tok_valid = 1 after edge N when the FIFO was empty. There is no combinational path from in_char to the tok_* outputs.
- FIFO handshake and boundaries:
  - Head pops when tok_valid & tok_ready.
  - Push and pop in the same cycle are both honoured; the count changes by pushes minus pops.
  - Pointers wrap modulo FIFO_DEPTH.
  - tok_kind and tok_len hold stable while tok_valid & !tok_ready.
  - Full: in_ready stays 0 and no character is lost.
  - Empty: tok_valid = 0 and tok_* are don't-care.

Decomposition:
- Package tok_pkg holds:
  - token kind constants TOK_OTHER / TOK_BEGIN / TOK_END / TOK_EOS;
  - DELIM = 8'h20;
  - keyword byte constants for "begin" and "end";
  - FSM state encodings GAP / WORD.
- One sub-module, tok_fifo: a synchronous FIFO, 6 bits wide (kind + len), that supports 2 pushes per cycle and exposes a free-entry count. The tokenizer FSM and matcher stay in word_tokenizer.

Test Plan:
- Basic classification: "Begin end " with tok_ready held at 1 -> tokens BEGIN/5, END/3; no further tokens; tok_valid is 1 on the cycle after each delimiter is accepted.
- Near misses and folding: "BEGINX en ENd" with in_last on the final 'd' -> OTHER/6, OTHER/2, END/3, EOS/0, in that order, with END and EOS pushed on the same edge.
- Spacing edge cases: stream "   " with in_last on the third space -> only EOS/0. A stream made of a single space with in_last -> only EOS/0.
- Overlong word: 20 x 'a' then a space -> one OTHER token with tok_len = 15.
- Back-pressure: tok_ready = 0 while "a b c d e " is driven -> in_ready falls to 0 once 3 tokens are queued (FIFO_DEPTH 4), no character is dropped, and the head holds OTHER/1 stable. Releasing tok_ready then delivers all 5 OTHER/1 tokens in order.
- Reset mid-operation: drive "beg", then pull reset low for 1 cycle, then drive "end " -> tok_valid = 0 during reset; only END/3 is produced afterwards; no token for "beg".

Source files
------------

// File: rtl/tok_pkg.sv
// ----------------------------------------------------------------------------
// tok_pkg
// Shared definitions for the word tokenizer:
//   - token kind encodings carried on tok_kind
//   - the single delimiter byte
//   - keyword byte strings for "begin" and "end" and their lengths
//   - tokenizer FSM state encoding
//   - helpers: ASCII upper-to-lower folding, per-position keyword match,
//     and final word classification
// ----------------------------------------------------------------------------
package tok_pkg;

    // Token kinds as presented on tok_kind
    localparam logic [1:0] TOK_OTHER = 2'd0;
    localparam logic [1:0] TOK_BEGIN = 2'd1;
    localparam logic [1:0] TOK_END   = 2'd2;
    localparam logic [1:0] TOK_EOS   = 2'd3;

    // Only the space character separates words
    localparam logic [7:0] DELIM = 8'h20;

    // Keywords, first character in the most significant byte
    localparam logic [39:0] KW_BEGIN     = "begin";
    localparam logic [3:0]  KW_BEGIN_LEN = 4'd5;
    localparam logic [23:0] KW_END       = "end";
    localparam logic [3:0]  KW_END_LEN   = 4'd3;

    // Tokenizer FSM
    typedef enum logic {
        GAP  = 1'b0,
        WORD = 1'b1
    } state_t;

    // Map 'A'..'Z' onto 'a'..'z'; every other byte is left alone
    function automatic logic [7:0] fold_case(input logic [7:0] c);
        logic [7:0] r;
        r = c;
        if (c >= 8'h41 && c <= 8'h5A) begin
            r = c | 8'h20;
        end
        return r;
    endfunction

    // True when folded character c equals "begin"[pos]; false past the keyword
    function automatic logic match_begin(input logic [3:0] pos, input logic [7:0] c);
        logic [7:0] kw;
        kw = 8'h00;
        case (pos)
            4'd0:    kw = KW_BEGIN[39:32];
            4'd1:    kw = KW_BEGIN[31:24];
            4'd2:    kw = KW_BEGIN[23:16];
            4'd3:    kw = KW_BEGIN[15:8];
            4'd4:    kw = KW_BEGIN[7:0];
            default: kw = 8'h00;
        endcase
        return (pos < KW_BEGIN_LEN) && (c == kw);
    endfunction

    // True when folded character c equals "end"[pos]; false past the keyword
    function automatic logic match_end(input logic [3:0] pos, input logic [7:0] c);
        logic [7:0] kw;
        kw = 8'h00;
        case (pos)
            4'd0:    kw = KW_END[23:16];
            4'd1:    kw = KW_END[15:8];
            4'd2:    kw = KW_END[7:0];
            default: kw = 8'h00;
        endcase
        return (pos < KW_END_LEN) && (c == kw);
    endfunction

    // Final classification of a finished word. A word that overflowed the
    // length counter can never be a keyword, whatever its saturated length.
    function automatic logic [1:0] classify(
        input logic [3:0] len,
        input logic       begin_ok,
        input logic       end_ok,
        input logic       overflow
    );
        logic [1:0] k;
        k = TOK_OTHER;
        if (!overflow && begin_ok && len == KW_BEGIN_LEN) begin
            k = TOK_BEGIN;
        end else if (!overflow && end_ok && len == KW_END_LEN) begin
            k = TOK_END;
        end
        return k;
    endfunction

endpackage

// File: rtl/tok_fifo.sv
// ----------------------------------------------------------------------------
// tok_fifo
// Small synchronous token FIFO with two write lanes per cycle.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset; empties the FIFO
//   push0       write lane 0 enable
//   push0_data  lane 0 data (written first, i.e. nearer the head)
//   push1       write lane 1 enable; only meaningful together with push0
//   push1_data  lane 1 data
//   pop         remove the head entry (ignored when empty)
//   head_valid  FIFO holds at least one entry
//   head_data   entry at the head (undefined when empty)
//   free_next   free entries once this cycle's pushes and pops have landed
//
// The writer must never push more than the free entries; the tokenizer
// guarantees this by only accepting a character while two entries are free.
// ----------------------------------------------------------------------------
module tok_fifo
    import tok_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push0,
    input  logic [W-1:0]             push0_data,
    input  logic                     push1,
    input  logic [W-1:0]             push1_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   free_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [W-1:0]  mem_reg [DEPTH];
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] wr_ptr_plus1;
    logic [CW-1:0] count_reg, count_next;
    logic          pop_ok;

    logic [DEPTH-1:0] wen;
    logic [W-1:0]     wdata [DEPTH];

    assign wr_ptr_plus1 = wr_ptr_reg + PTR_ONE;

    // Per-entry write decode: lane 0 lands at the write pointer, lane 1 in
    // the slot after it (pointer arithmetic wraps naturally at DEPTH).
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr
            logic hit0;
            logic hit1;
            assign hit0      = push0 && (wr_ptr_reg == AW'(gi));
            assign hit1      = push0 && push1 && (wr_ptr_plus1 == AW'(gi));
            assign wen[gi]   = hit0 || hit1;
            assign wdata[gi] = hit0 ? push0_data : push1_data;
        end
    endgenerate

    // Storage carries no reset; empty entries are never observed
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wen[i]) begin
                mem_reg[i] <= wdata[i];
            end
        end
    end

    assign head_valid = (count_reg != '0);
    assign head_data  = mem_reg[rd_ptr_reg];
    assign pop_ok     = pop && head_valid;

    always_comb begin
        rd_ptr_next = rd_ptr_reg + AW'(pop_ok);
        wr_ptr_next = wr_ptr_reg + AW'(push0) + AW'(push0 && push1);
        count_next  = count_reg + CW'(push0) + CW'(push0 && push1) - CW'(pop_ok);
        free_next   = CW'(DEPTH) - count_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

endmodule

// File: rtl/word_tokenizer.sv
// ----------------------------------------------------------------------------
// word_tokenizer
// Splits a byte stream into space-delimited words, classifies each word
// case-insensitively as BEGIN / END / OTHER and queues one token per word,
// plus an EOS token when the final character of a stream is accepted.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset; drops partial and queued tokens
//   in_valid   in_char / in_last are valid
//   in_ready   character accepted this cycle when in_valid is also high
//   in_char    ASCII character
//   in_last    final character of the stream
//   tok_valid  a token is available at the FIFO head
//   tok_ready  consumer takes the head token this cycle
//   tok_kind   0 OTHER, 1 BEGIN, 2 END, 3 EOS
//   tok_len    word length saturated at MAX_LEN; 0 for EOS
// ----------------------------------------------------------------------------
module word_tokenizer
    import tok_pkg::*;
#(
    parameter int MAX_LEN    = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    input  logic       in_last,
    output logic       tok_valid,
    input  logic       tok_ready,
    output logic [1:0] tok_kind,
    output logic [3:0] tok_len
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] LEN_MAX = 4'(MAX_LEN);

    // FSM state and word-in-progress bookkeeping
    state_t     state_reg;
    logic [3:0] len_reg;
    logic       begin_ok_reg;   // every character so far matches "begin"
    logic       end_ok_reg;     // every character so far matches "end"
    logic       ovf_reg;        // word grew beyond MAX_LEN
    logic       ready_reg;

    logic       accept;
    logic       is_delim;
    logic [7:0] ch;

    // The word as it stands once the current (non-delimiter) character is added
    logic [3:0] ext_len;
    logic       ext_begin_ok;
    logic       ext_end_ok;
    logic       ext_ovf;

    // The word being closed this cycle, if any
    logic [1:0] fin_kind;
    logic [3:0] fin_len;

    logic       push_word;
    logic       push_eos;
    logic       push0, push1;
    logic [5:0] push0_data, push1_data;

    logic       head_valid;
    logic [5:0] head_data;
    logic [CW-1:0] free_next;

    assign accept   = in_valid && ready_reg;
    assign is_delim = (in_char == DELIM);
    assign ch       = fold_case(in_char);

    always_comb begin
        ext_len      = 4'd1;
        ext_begin_ok = 1'b0;
        ext_end_ok   = 1'b0;
        ext_ovf      = 1'b0;
        if (state_reg == GAP) begin
            ext_len      = 4'd1;
            ext_begin_ok = match_begin(4'd0, ch);
            ext_end_ok   = match_end(4'd0, ch);
            ext_ovf      = 1'b0;
        end else begin
            // len_reg is the zero-based position of the incoming character
            ext_len      = (len_reg == LEN_MAX) ? len_reg : len_reg + 4'd1;
            ext_begin_ok = begin_ok_reg && match_begin(len_reg, ch);
            ext_end_ok   = end_ok_reg && match_end(len_reg, ch);
            ext_ovf      = ovf_reg || (len_reg == LEN_MAX);
        end
    end

    // A delimiter closes the word held in the registers; an in_last
    // non-delimiter closes the word including itself.
    always_comb begin
        if (is_delim) begin
            fin_kind = classify(len_reg, begin_ok_reg, end_ok_reg, ovf_reg);
            fin_len  = len_reg;
        end else begin
            fin_kind = classify(ext_len, ext_begin_ok, ext_end_ok, ext_ovf);
            fin_len  = ext_len;
        end
    end

    assign push_word = accept && (is_delim ? (state_reg == WORD) : in_last);
    assign push_eos  = accept && in_last;

    // Word token always goes on lane 0 so it precedes EOS in the queue
    assign push0      = push_word || push_eos;
    assign push0_data = push_word ? {fin_kind, fin_len} : {TOK_EOS, 4'd0};
    assign push1      = push_word && push_eos;
    assign push1_data = {TOK_EOS, 4'd0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= GAP;
            len_reg      <= 4'd0;
            begin_ok_reg <= 1'b0;
            end_ok_reg   <= 1'b0;
            ovf_reg      <= 1'b0;
            ready_reg    <= 1'b0;
        end else begin
            // Two free entries needed: one character may push word + EOS
            ready_reg <= (free_next >= CW'(2));
            if (accept) begin
                if (is_delim || in_last) begin
                    state_reg    <= GAP;
                    len_reg      <= 4'd0;
                    begin_ok_reg <= 1'b0;
                    end_ok_reg   <= 1'b0;
                    ovf_reg      <= 1'b0;
                end else begin
                    state_reg    <= WORD;
                    len_reg      <= ext_len;
                    begin_ok_reg <= ext_begin_ok;
                    end_ok_reg   <= ext_end_ok;
                    ovf_reg      <= ext_ovf;
                end
            end
        end
    end

    tok_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (6)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push0      (push0),
        .push0_data (push0_data),
        .push1      (push1),
        .push1_data (push1_data),
        .pop        (tok_ready),
        .head_valid (head_valid),
        .head_data  (head_data),
        .free_next  (free_next)
    );

    assign in_ready  = ready_reg;
    assign tok_valid = head_valid;
    // Zero the payload while empty so reset and idle show kind 0 / len 0
    assign tok_kind  = head_valid ? head_data[5:4] : 2'd0;
    assign tok_len   = head_valid ? head_data[3:0] : 4'd0;

endmodule
